rom_sync: RTL and testbench

// - Parametrised, registered-read ROM with a valid/ready request and response handshake.
// - Successor to the fixed 8x8 combinational ROM; feeds instruction/constant fetch in the CPU datapath.
// - Content is a closed-form pattern: word[a] = BASE + a, truncated to DATA_W.
// - Addresses at or above DEPTH return an error response.
//

---
 rtl/rom_pkg.sv | 16 +
 rtl/rom_table.sv | 24 ++
 rtl/rom_sync.sv | 99 +++++++++
 tb/tb_rom_sync.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared constants, content rule and state type for the registered-read ROM.
package rom_pkg;

  localparam int          ROM_DATA_W = 8;
  localparam int          ROM_ADDR_W = 3;
  localparam int          ROM_DEPTH  = 8;
  localparam logic [31:0] ROM_BASE   = 32'h10;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} rom_state_e;

  // Caller keeps the low DATA_W bits; the 48-bit sum never loses a carry first.
  function automatic logic [47:0] rom_word(input logic [31:0] base, input logic [15:0] addr);
    return 48'(base) + 48'(addr);
  endfunction

endpackage

// File: rtl/rom_table.sv
// Combinational ROM content: address -> {err, data}, data forced to 0 when out of range.
module rom_table
  import rom_pkg::*;
#(
  parameter int          DATA_W = ROM_DATA_W,
  parameter int          ADDR_W = ROM_ADDR_W,
  parameter int          DEPTH  = ROM_DEPTH,
  parameter logic [31:0] BASE   = ROM_BASE
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_err,
  output logic [DATA_W-1:0] o_data
);

  logic              w_err;
  logic [DATA_W-1:0] w_word;

  assign w_err  = (17'(i_addr) >= 17'(DEPTH));
  assign w_word = DATA_W'(rom_word(BASE, 16'(i_addr)));

  assign o_err  = w_err;
  assign o_data = w_err ? '0 : w_word;

endmodule

// File: rtl/rom_sync.sv
// Registered-read ROM with valid/ready handshake and saturating access counter.
// Define ROM_PARITY_EN to add the registered even-parity output rsp_par.
module rom_sync
  import rom_pkg::*;
#(
  parameter int          DATA_W = ROM_DATA_W,
  parameter int          ADDR_W = ROM_ADDR_W,
  parameter int          DEPTH  = ROM_DEPTH,
  parameter logic [31:0] BASE   = ROM_BASE,
  parameter int          CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  rd_count
`ifdef ROM_PARITY_EN
  ,
  output logic              rsp_par
`endif
);

  rom_state_e        r_state;
  rom_state_e        w_state_nxt;
  logic              w_accept;
  logic              w_tbl_err;
  logic [DATA_W-1:0] w_tbl_data;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  rom_table #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .BASE   (BASE)
  ) u_table (
    .i_addr (req_addr),
    .o_err  (w_tbl_err),
    .o_data (w_tbl_data)
  );

  // Ready depends only on the output register and rsp_ready, never on req_*.
  assign req_ready = (r_state == ST_EMPTY) | rsp_ready;
  assign w_accept  = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_accept)       w_state_nxt = ST_FULL;
        else if (rsp_ready) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_data <= w_tbl_data;
      r_err  <= w_tbl_err;
    end
  end

  // Counts error requests too; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (w_accept && ~&r_cnt)    r_cnt <= r_cnt + 1'b1;
  end

`ifdef ROM_PARITY_EN
  logic r_par;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_par <= 1'b0;
    else if (w_accept) r_par <= ^w_tbl_data;
  end
  assign rsp_par = r_par;
`endif

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;
  assign rd_count  = r_cnt;

endmodule

// File: tb/tb_rom_sync.sv
// Directed bench: four rom_sync configurations driven by one shared request stream.
module tb_rom_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [2:0] req_addr;
  logic       rsp_ready;

  // Instance 0: defaults, 1: DEPTH=6, 2: BASE='hFE, 3: CNT_W=3
  logic       req_ready [4];
  logic       rsp_valid [4];
  logic [7:0] rsp_data  [4];
  logic       rsp_err   [4];
  logic       rsp_par   [4];
  logic [15:0] cnt16    [3];
  logic [2:0]  cnt3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rom_sync u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_addr(req_addr), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]), .rd_count(cnt16[0])
`ifdef ROM_PARITY_EN
    , .rsp_par(rsp_par[0])
`endif
  );

  rom_sync #(.DEPTH(6)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_addr(req_addr), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]), .rd_count(cnt16[1])
`ifdef ROM_PARITY_EN
    , .rsp_par(rsp_par[1])
`endif
  );

  rom_sync #(.BASE(32'hFE)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[2]),
    .req_addr(req_addr), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data[2]), .rsp_err(rsp_err[2]), .rd_count(cnt16[2])
`ifdef ROM_PARITY_EN
    , .rsp_par(rsp_par[2])
`endif
  );

  rom_sync #(.CNT_W(3)) u_d (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[3]),
    .req_addr(req_addr), .rsp_valid(rsp_valid[3]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data[3]), .rsp_err(rsp_err[3]), .rd_count(cnt3)
`ifdef ROM_PARITY_EN
    , .rsp_par(rsp_par[3])
`endif
  );

`ifndef ROM_PARITY_EN
  initial for (int i = 0; i < 4; i++) rsp_par[i] = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Expected words, hand-computed: default BASE 'h10, DEPTH=6 table, BASE 'hFE table
  logic [7:0] exp_a [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
  logic [7:0] exp_b [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h00, 8'h00};
  logic       err_b [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] exp_c [8] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
  logic [2:0] cnt3_exp  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 3'd0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("reset rsp_data",  32'(rsp_data[0]),  32'd0);
    chk("reset rsp_err",   32'(rsp_err[0]),   32'd0);
    chk("reset rd_count",  32'(cnt16[0]),     32'd0);
    chk("reset req_ready", 32'(req_ready[0]), 32'd1);
`ifdef ROM_PARITY_EN
    chk("reset rsp_par",   32'(rsp_par[0]),   32'd0);
`endif
    rst_n = 1'b1;

    // Back-to-back reads of every address, one word per cycle
    @(negedge clk);
    req_valid = 1'b1; req_addr = 3'd0; rsp_ready = 1'b1;
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      chk($sformatf("b2b valid a%0d", a), 32'(rsp_valid[0]), 32'd1);
      chk($sformatf("b2b data a%0d", a),  32'(rsp_data[0]),  32'(exp_a[a]));
      chk($sformatf("depth6 data a%0d", a), 32'(rsp_data[1]), 32'(exp_b[a]));
      chk($sformatf("depth6 err a%0d", a),  32'(rsp_err[1]),  32'(err_b[a]));
      chk($sformatf("base_fe data a%0d", a), 32'(rsp_data[2]), 32'(exp_c[a]));
      chk($sformatf("cnt3 a%0d", a), 32'(cnt3), 32'(cnt3_exp[a]));
      if (a < 7) req_addr = 3'(a + 1);
      else       req_valid = 1'b0;
    end
    chk("rd_count after 8", 32'(cnt16[0]), 32'd8);
    @(negedge clk);
    chk("drain rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rd_count idle",   32'(cnt16[0]),     32'd8);

    // Backpressure: addr 3 held while addr 5 waits
    req_valid = 1'b1; req_addr = 3'd3;
    @(negedge clk);
    chk("bp first data", 32'(rsp_data[0]), 32'h13);
`ifdef ROM_PARITY_EN
    chk("par 'h13", 32'(rsp_par[0]), 32'd1);
`endif
    req_addr = 3'd5; rsp_ready = 1'b0;
    #1 chk("bp req_ready low", 32'(req_ready[0]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("bp hold data c%0d", i),  32'(rsp_data[0]),  32'h13);
      chk($sformatf("bp hold valid c%0d", i), 32'(rsp_valid[0]), 32'd1);
      chk($sformatf("bp hold ready c%0d", i), 32'(req_ready[0]), 32'd0);
    end
    rsp_ready = 1'b1;
    #1 chk("bp release ready", 32'(req_ready[0]), 32'd1);
    chk("bp release data", 32'(rsp_data[0]), 32'h13);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp second data", 32'(rsp_data[0]), 32'h15);
    chk("bp second valid", 32'(rsp_valid[0]), 32'd1);
    @(negedge clk);
    chk("bp drained", 32'(rsp_valid[0]), 32'd0);
    chk("rd_count after 10", 32'(cnt16[0]), 32'd10);
    chk("cnt3 saturated", 32'(cnt3), 32'd7);

    // Error response carries no parity; addr 0 gives 'h10
    req_valid = 1'b1; req_addr = 3'd7;
    @(negedge clk);
    req_addr = 3'd0;
    chk("depth6 err a7 late", 32'(rsp_err[1]), 32'd1);
`ifdef ROM_PARITY_EN
    chk("par err", 32'(rsp_par[1]), 32'd0);
`endif
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk("addr0 data", 32'(rsp_data[0]), 32'h10);
    chk("depth6 err cleared", 32'(rsp_err[1]), 32'd0);
`ifdef ROM_PARITY_EN
    chk("par 'h10", 32'(rsp_par[0]), 32'd1);
`endif

    // Reset while FULL discards the held word
    chk("pre-reset full", 32'(rsp_valid[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async reset valid", 32'(rsp_valid[0]), 32'd0);
    chk("async reset count", 32'(cnt16[0]), 32'd0);
    chk("async reset data",  32'(rsp_data[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post-reset valid", 32'(rsp_valid[0]), 32'd0);
    req_valid = 1'b1; req_addr = 3'd2;
    @(negedge clk);
    req_valid = 1'b0;
    chk("post-reset read", 32'(rsp_data[0]), 32'h12);
    chk("post-reset count", 32'(cnt16[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
